// File: rtl/renkon_conv_window.sv
`timescale 1ns/1ps
// renkon_conv_window
// Sliding 5x5 window builder that feeds the 5x5 convolution core. A raster
// ordered WxW pixel stream is pushed through four line buffers (one per
// previous row) and a 5x5 register array. Every pixel that completes a fully
// populated window produces one out_valid pulse one clock later.
//
// Output handshake: out_valid is a one-cycle strobe with no back-pressure.
// The consumer must take pixel_out0..24 in the cycle out_valid is 1. Taps
// change only on an accepted pixel (in_en=1 and buf_start=0), and out_valid
// is 0 in every cycle that follows a cycle without an accepted pixel.
module renkon_conv_window #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 9,
  parameter int MAXW   = 256
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     buf_start,
  input  logic [LWIDTH-1:0]        img_size,
  input  logic                     in_en,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic signed [DWIDTH-1:0] pixel_out0,
  output logic signed [DWIDTH-1:0] pixel_out1,
  output logic signed [DWIDTH-1:0] pixel_out2,
  output logic signed [DWIDTH-1:0] pixel_out3,
  output logic signed [DWIDTH-1:0] pixel_out4,
  output logic signed [DWIDTH-1:0] pixel_out5,
  output logic signed [DWIDTH-1:0] pixel_out6,
  output logic signed [DWIDTH-1:0] pixel_out7,
  output logic signed [DWIDTH-1:0] pixel_out8,
  output logic signed [DWIDTH-1:0] pixel_out9,
  output logic signed [DWIDTH-1:0] pixel_out10,
  output logic signed [DWIDTH-1:0] pixel_out11,
  output logic signed [DWIDTH-1:0] pixel_out12,
  output logic signed [DWIDTH-1:0] pixel_out13,
  output logic signed [DWIDTH-1:0] pixel_out14,
  output logic signed [DWIDTH-1:0] pixel_out15,
  output logic signed [DWIDTH-1:0] pixel_out16,
  output logic signed [DWIDTH-1:0] pixel_out17,
  output logic signed [DWIDTH-1:0] pixel_out18,
  output logic signed [DWIDTH-1:0] pixel_out19,
  output logic signed [DWIDTH-1:0] pixel_out20,
  output logic signed [DWIDTH-1:0] pixel_out21,
  output logic signed [DWIDTH-1:0] pixel_out22,
  output logic signed [DWIDTH-1:0] pixel_out23,
  output logic signed [DWIDTH-1:0] pixel_out24,
  output logic                     out_valid
);

  // Line buffer address width; depth is rounded up to a power of two so any
  // column value truncated to AW bits stays inside the array. Oversized
  // images (img_size > MAXW) alias addresses, but their output is masked.
  localparam int AW    = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int DEPTH = 2 ** AW;

  localparam logic [LWIDTH-1:0] ONE    = LWIDTH'(1);
  localparam logic [LWIDTH-1:0] FOUR   = LWIDTH'(4);
  localparam logic [LWIDTH-1:0] MIN_W  = LWIDTH'(5);
  localparam logic [LWIDTH:0]   MAXW_L = (LWIDTH+1)'(MAXW);

  // Raster position of the pixel being accepted this cycle
  logic [LWIDTH-1:0] r_col;
  logic [LWIDTH-1:0] r_row;
  logic              r_out_valid;

  // Window registers: [r][c], r=0 oldest row (top), c=0 oldest column (left)
  logic [DWIDTH-1:0] r_win [5][5];

  // Line buffers: lb0 holds the previous row, lb3 the row four rows back.
  // Contents are never reset; stale data only reaches masked windows.
  logic [DWIDTH-1:0] r_lb0 [DEPTH];
  logic [DWIDTH-1:0] r_lb1 [DEPTH];
  logic [DWIDTH-1:0] r_lb2 [DEPTH];
  logic [DWIDTH-1:0] r_lb3 [DEPTH];

  logic [AW-1:0]     w_addr;
  logic [LWIDTH-1:0] w_last;
  logic              w_size_ok;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_advance;
  logic              w_win_full;
  logic [DWIDTH-1:0] w_new_col [5];

  // A frame restart takes priority over a pixel presented in the same cycle
  assign w_advance  = in_en & ~buf_start;
  assign w_addr     = r_col[AW-1:0];
  assign w_last     = img_size - ONE;
  assign w_col_last = (r_col == w_last);
  assign w_row_last = (r_row == w_last);
  assign w_size_ok  = (img_size >= MIN_W) && ({1'b0, img_size} <= MAXW_L);
  // The incoming pixel closes a 5x5 window only from row 4 / col 4 onward,
  // which also keeps windows from straddling a row wrap.
  assign w_win_full = (r_row >= FOUR) && (r_col >= FOUR);

  // New right-hand column, top (oldest row) to bottom (incoming pixel)
  assign w_new_col[0] = r_lb3[w_addr];
  assign w_new_col[1] = r_lb2[w_addr];
  assign w_new_col[2] = r_lb1[w_addr];
  assign w_new_col[3] = r_lb0[w_addr];
  assign w_new_col[4] = pixel_in;

  // Raster column/row counters with wrap at line end and frame end
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (buf_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_en) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + ONE;
        end
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

  // Registered valid strobe: one clock after the pixel that completes a window
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_advance & w_size_ok & w_win_full;
    end
  end

  // Window shifts left one column per accepted pixel
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_advance) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][4] <= w_new_col[r];
      end
    end
  end

  // Line buffers cascade one row deeper at the current column
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_lb0[w_addr] <= pixel_in;
      r_lb1[w_addr] <= r_lb0[w_addr];
      r_lb2[w_addr] <= r_lb1[w_addr];
      r_lb3[w_addr] <= r_lb2[w_addr];
    end
  end

  assign out_valid   = r_out_valid;

  assign pixel_out0  = r_win[0][0];
  assign pixel_out1  = r_win[0][1];
  assign pixel_out2  = r_win[0][2];
  assign pixel_out3  = r_win[0][3];
  assign pixel_out4  = r_win[0][4];
  assign pixel_out5  = r_win[1][0];
  assign pixel_out6  = r_win[1][1];
  assign pixel_out7  = r_win[1][2];
  assign pixel_out8  = r_win[1][3];
  assign pixel_out9  = r_win[1][4];
  assign pixel_out10 = r_win[2][0];
  assign pixel_out11 = r_win[2][1];
  assign pixel_out12 = r_win[2][2];
  assign pixel_out13 = r_win[2][3];
  assign pixel_out14 = r_win[2][4];
  assign pixel_out15 = r_win[3][0];
  assign pixel_out16 = r_win[3][1];
  assign pixel_out17 = r_win[3][2];
  assign pixel_out18 = r_win[3][3];
  assign pixel_out19 = r_win[3][4];
  assign pixel_out20 = r_win[4][0];
  assign pixel_out21 = r_win[4][1];
  assign pixel_out22 = r_win[4][2];
  assign pixel_out23 = r_win[4][3];
  assign pixel_out24 = r_win[4][4];

endmodule

// File: tb/tb_renkon_conv_window.sv
`timescale 1ns/1ps
// Testbench for renkon_conv_window: drives raster frames, keeps an image
// model, pushes the expected 5x5 window for every completing pixel and
// compares it against each out_valid strobe.
module tb_renkon_conv_window;

  localparam int DW      = 16;
  localparam int LW      = 9;
  localparam int TB_MAXW = 32;
  localparam int WINW    = 25 * DW;
  localparam int CYCLE_LIMIT = 20000;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk;
  logic                 xrst;
  logic                 buf_start;
  logic [LW-1:0]        img_size;
  logic                 in_en;
  logic signed [DW-1:0] pixel_in;
  logic signed [DW-1:0] pixel_out0,  pixel_out1,  pixel_out2,  pixel_out3,  pixel_out4;
  logic signed [DW-1:0] pixel_out5,  pixel_out6,  pixel_out7,  pixel_out8,  pixel_out9;
  logic signed [DW-1:0] pixel_out10, pixel_out11, pixel_out12, pixel_out13, pixel_out14;
  logic signed [DW-1:0] pixel_out15, pixel_out16, pixel_out17, pixel_out18, pixel_out19;
  logic signed [DW-1:0] pixel_out20, pixel_out21, pixel_out22, pixel_out23, pixel_out24;
  logic                 out_valid;
  logic [WINW-1:0]      w_act;

  logic [WINW-1:0] exp_q[$];
  logic [WINW-1:0] got_q[$];
  logic [DW-1:0]   img_m [0:TB_MAXW][0:TB_MAXW];
  int              total;
  int              bad;
  int              n_win;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  renkon_conv_window #(
    .DWIDTH (DW),
    .LWIDTH (LW),
    .MAXW   (TB_MAXW)
  ) dut (
    .clk         (clk),
    .xrst        (xrst),
    .buf_start   (buf_start),
    .img_size    (img_size),
    .in_en       (in_en),
    .pixel_in    (pixel_in),
    .pixel_out0  (pixel_out0),
    .pixel_out1  (pixel_out1),
    .pixel_out2  (pixel_out2),
    .pixel_out3  (pixel_out3),
    .pixel_out4  (pixel_out4),
    .pixel_out5  (pixel_out5),
    .pixel_out6  (pixel_out6),
    .pixel_out7  (pixel_out7),
    .pixel_out8  (pixel_out8),
    .pixel_out9  (pixel_out9),
    .pixel_out10 (pixel_out10),
    .pixel_out11 (pixel_out11),
    .pixel_out12 (pixel_out12),
    .pixel_out13 (pixel_out13),
    .pixel_out14 (pixel_out14),
    .pixel_out15 (pixel_out15),
    .pixel_out16 (pixel_out16),
    .pixel_out17 (pixel_out17),
    .pixel_out18 (pixel_out18),
    .pixel_out19 (pixel_out19),
    .pixel_out20 (pixel_out20),
    .pixel_out21 (pixel_out21),
    .pixel_out22 (pixel_out22),
    .pixel_out23 (pixel_out23),
    .pixel_out24 (pixel_out24),
    .out_valid   (out_valid)
  );

  assign w_act = {pixel_out24, pixel_out23, pixel_out22, pixel_out21, pixel_out20,
                  pixel_out19, pixel_out18, pixel_out17, pixel_out16, pixel_out15,
                  pixel_out14, pixel_out13, pixel_out12, pixel_out11, pixel_out10,
                  pixel_out9,  pixel_out8,  pixel_out7,  pixel_out6,  pixel_out5,
                  pixel_out4,  pixel_out3,  pixel_out2,  pixel_out1,  pixel_out0};

  // Hard stop so the run can never hang
  initial begin
    #(CYCLE_LIMIT * 10);
    $display("FAIL watchdog: simulation reached %0d cycles, required finish earlier", CYCLE_LIMIT);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_en     = 1'b0;
    buf_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_px(input logic [DW-1:0] v);
    in_en     = 1'b1;
    buf_start = 1'b0;
    pixel_in  = v;
    @(posedge clk);
    #1;
  endtask

  // Record a pixel in the image model; if it completes a window on a
  // supported size, queue the expected 5x5 window (tap k = 5*r + c).
  task automatic model_push(input int w, input int r, input int c, input logic [DW-1:0] v);
    logic [WINW-1:0] e;
    img_m[r][c] = v;
    if (w >= 5 && w <= TB_MAXW && r >= 4 && c >= 4) begin
      e = '0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          e[(5*i+j)*DW +: DW] = img_m[r-4+i][c-4+j];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // One full frame; gap_pct is the chance of an idle cycle before a pixel
  task automatic send_frame(input int w, input int offset, input int gap_pct, input bit rnd);
    logic [DW-1:0] v;
    img_size = LW'(w);
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
        v = rnd ? DW'($urandom) : DW'(offset + r*w + c);
        model_push(w, r, c, v);
        drive_px(v);
      end
    end
    in_en = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic scoreboard_mon();
    logic            en_edge;
    logic [WINW-1:0] e;
    forever begin
      @(posedge clk);
      en_edge = in_en & ~buf_start;
      @(negedge clk);
      if (xrst === 1'b1 && out_valid === 1'b1) begin
        got_q.push_back(w_act);
        n_win++;
        total++;
        if (en_edge !== 1'b1) begin
          bad++;
          $display("FAIL valid_after_idle: out_valid=1 required=0 at %0t", $time);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_window: got %h required no window at %0t", w_act, $time);
        end else begin
          e = exp_q.pop_front();
          if (w_act !== e) begin
            bad++;
            $display("FAIL window_data: got %h required %h at %0t", w_act, e, $time);
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b required 0", out_valid);
    end
    total++;
    if (w_act !== '0) begin
      bad++;
      $display("FAIL reset_taps: got %h required 0", w_act);
    end
    xrst = 1'b1;
    idle(2);
  endtask

  task automatic test_w8();
    n_win = 0;
    got_q.delete();
    img_size = LW'(8);
    for (int p = 0; p < 64; p++) begin
      model_push(8, p / 8, p % 8, DW'(p));
      drive_px(DW'(p));
      if (p == 35) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL w8_early_valid: got %b required 0 after pixel 35", out_valid);
        end
      end
      if (p == 36) begin
        total++;
        if (out_valid !== 1'b1) begin
          bad++;
          $display("FAIL w8_first_valid: got %b required 1 after pixel 36", out_valid);
        end
        total++;
        if (pixel_out0 !== 16'sd0 || pixel_out12 !== 16'sd18 || pixel_out24 !== 16'sd36) begin
          bad++;
          $display("FAIL w8_first_taps: got %0d/%0d/%0d required 0/18/36",
                   pixel_out0, pixel_out12, pixel_out24);
        end
      end
    end
    in_en = 1'b0;
    idle(3);
    total++;
    if (n_win !== 16) begin
      bad++;
      $display("FAIL w8_count: got %0d required 16", n_win);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL w8_missing: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_gaps();
    logic [WINW-1:0] f;
    n_win = 0;
    got_q.delete();
    send_frame(8, 0, 40, 1'b0);
    idle(3);
    total++;
    if (n_win !== 16 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL gaps_count: got %0d windows %0d pending required 16 and 0", n_win, exp_q.size());
    end
    f = got_q[0];
    total++;
    if (f[0 +: DW] !== 16'd0 || f[24*DW +: DW] !== 16'd36) begin
      bad++;
      $display("FAIL gaps_first: got %0d/%0d required 0/36", f[0 +: DW], f[24*DW +: DW]);
    end
  endtask

  task automatic test_back_to_back();
    logic [WINW-1:0] f;
    bit              stale;
    n_win = 0;
    got_q.delete();
    send_frame(8, 0, 0, 1'b0);
    send_frame(8, 100, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 32 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d windows %0d pending required 32 and 0", n_win, exp_q.size());
    end
    f = got_q[16];
    total++;
    if (f[0 +: DW] !== 16'd100 || f[24*DW +: DW] !== 16'd136) begin
      bad++;
      $display("FAIL b2b_first: got %0d/%0d required 100/136", f[0 +: DW], f[24*DW +: DW]);
    end
    stale = 1'b0;
    for (int k = 16; k < 32; k++) begin
      f = got_q[k];
      for (int j = 0; j < 25; j++) begin
        if (f[j*DW +: DW] < 16'd100) stale = 1'b1;
      end
    end
    total++;
    if (stale !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stale: got %b required 0 (frame-1 value in frame-2 window)", stale);
    end
  endtask

  task automatic test_buf_start();
    logic [WINW-1:0] f;
    n_win = 0;
    got_q.delete();
    img_size = LW'(8);
    for (int p = 0; p <= 20; p++) begin
      model_push(8, p / 8, p % 8, DW'(50 + p));
      drive_px(DW'(50 + p));
    end
    in_en     = 1'b0;
    buf_start = 1'b1;
    @(posedge clk);
    #1;
    buf_start = 1'b0;
    send_frame(8, 200, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 16 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL restart_count: got %0d windows %0d pending required 16 and 0", n_win, exp_q.size());
    end
    f = got_q[0];
    total++;
    if (f[0 +: DW] !== 16'd200 || f[24*DW +: DW] !== 16'd236) begin
      bad++;
      $display("FAIL restart_first: got %0d/%0d required 200/236", f[0 +: DW], f[24*DW +: DW]);
    end
    // buf_start together with a pixel: the pixel must be dropped
    n_win = 0;
    got_q.delete();
    for (int p = 0; p < 10; p++) begin
      model_push(8, p / 8, p % 8, DW'(300 + p));
      drive_px(DW'(300 + p));
    end
    buf_start = 1'b1;
    in_en     = 1'b1;
    pixel_in  = 16'sh7777;
    @(posedge clk);
    #1;
    buf_start = 1'b0;
    in_en     = 1'b0;
    send_frame(8, 400, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 16 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL drop_count: got %0d windows %0d pending required 16 and 0", n_win, exp_q.size());
    end
    f = got_q[0];
    total++;
    if (f[0 +: DW] !== 16'd400 || f[24*DW +: DW] !== 16'd436) begin
      bad++;
      $display("FAIL drop_first: got %0d/%0d required 400/436", f[0 +: DW], f[24*DW +: DW]);
    end
  endtask

  task automatic test_reset_mid();
    n_win = 0;
    got_q.delete();
    img_size = LW'(8);
    for (int p = 0; p <= 36; p++) begin
      model_push(8, p / 8, p % 8, DW'(600 + p));
      drive_px(DW'(600 + p));
    end
    in_en = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre_valid: got %b required 1", out_valid);
    end
    #1;
    xrst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_valid: got %b required 0", out_valid);
    end
    total++;
    if (w_act !== '0) begin
      bad++;
      $display("FAIL midreset_taps: got %h required 0", w_act);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b1;
    n_win = 0;
    got_q.delete();
    send_frame(8, 500, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 16 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL midreset_frame: got %0d windows %0d pending required 16 and 0", n_win, exp_q.size());
    end
  endtask

  task automatic test_sizes();
    logic [WINW-1:0] f;
    n_win = 0;
    send_frame(4, 0, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 0) begin
      bad++;
      $display("FAIL size4_count: got %0d required 0", n_win);
    end
    n_win = 0;
    send_frame(TB_MAXW + 1, 0, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 0) begin
      bad++;
      $display("FAIL size_over_count: got %0d required 0", n_win);
    end
    n_win = 0;
    got_q.delete();
    send_frame(5, 0, 0, 1'b0);
    idle(3);
    total++;
    if (n_win !== 1) begin
      bad++;
      $display("FAIL size5_count: got %0d required 1", n_win);
    end
    f = got_q[0];
    total++;
    if (f[0 +: DW] !== 16'd0 || f[24*DW +: DW] !== 16'd24) begin
      bad++;
      $display("FAIL size5_taps: got %0d/%0d required 0/24", f[0 +: DW], f[24*DW +: DW]);
    end
    n_win = 0;
    send_frame(TB_MAXW, 0, 20, 1'b1);
    idle(3);
    total++;
    if (n_win !== (TB_MAXW - 4) * (TB_MAXW - 4) || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL size_max_count: got %0d windows %0d pending required %0d and 0",
               n_win, exp_q.size(), (TB_MAXW - 4) * (TB_MAXW - 4));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total     = 0;
    bad       = 0;
    n_win     = 0;
    xrst      = 1'b0;
    buf_start = 1'b0;
    in_en     = 1'b0;
    pixel_in  = '0;
    img_size  = LW'(8);
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_w8();
    test_gaps();
    test_back_to_back();
    test_buf_start();
    test_reset_mid();
    test_sizes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
